// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: computes D = A - B - Bin over WIDTH bits.
// It processes one 4-bit nibble per clock, starting with the LSB nibble.
// A borrow register carries the borrow from one nibble to the next.
// Operands are taken in and results are handed off with valid/ready handshakes.
// Optional feature: define NIBBLE_SUB_OVERFLOW_FLAG_EN to add the registered
// signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands; in_ready=1
// RUN   | subtracting nibble idx; the result builds up in D
// DONE  | result held; out_valid=1 until out_ready
module nibble_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             Bout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             borrow;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [4:0]       diff;

  // Select the current nibble and do a 5-bit subtract; bit 4 is the borrow out
  always_comb begin
    a_sh = a_reg >> {idx, 2'b00};
    b_sh = b_reg >> {idx, 2'b00};
    diff = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, borrow};
  end

  // Ready only when idle; a held reset blocks accepts straight away
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // Sequencer: capture the operands, ripple the nibbles, hold the result until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      borrow    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      D         <= '0;
      Bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < N; n++) begin
            if (idx == IW'(n)) D[4*n +: 4] <= diff[3:0];
          end
          borrow <= diff[4];
          if (idx == LAST) begin
            Bout      <= diff[4];
`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
            // The MSB of the finished D is bit 3 of this final nibble
            ovf       <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                         (diff[3] != a_reg[WIDTH-1]);
`endif
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed testbench for nibble_serial_subtractor with WIDTH=32.
// Outputs are sampled 1ns after each rising edge.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  nibble_serial_subtractor #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
    .ovf      (ovf),
`endif
    .Bout     (Bout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge: 7 edges with no result, then valid on the 8th
  task automatic wait_result(input string tag);
    check({tag, "_rdy_run0"}, {31'b0, in_ready}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check({tag, "_ov_run"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_rdy_run"}, {31'b0, in_ready}, 32'd0);
    end
    tick();
    check({tag, "_ov_done"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_rdy_done"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; Bin = 1'b1;
    wait_result(tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    #23;
    check("rst_ov", {31'b0, out_valid}, 32'd0);
    check("rst_d", D, 32'd0);
    check("rst_bout", {31'b0, Bout}, 32'd0);
    check("rst_rdy", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_rdy", {31'b0, in_ready}, 32'd1);

    // 5 - 3; out_ready stays low so DONE holds for a while
    run_op("op1", 32'h0000_0005, 32'h0000_0003, 1'b0);
    check("op1_d", D, 32'h0000_0002);
    check("op1_bout", {31'b0, Bout}, 32'd0);
    tick();
    check("op1_hold", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("op1_ov_clr", {31'b0, out_valid}, 32'd0);
    check("op1_rdy", {31'b0, in_ready}, 32'd1);

    // 0 - 1: the borrow ripples through every nibble; out_ready already high
    run_op("op2", 32'h0000_0000, 32'h0000_0001, 1'b0);
    check("op2_d", D, 32'hFFFF_FFFF);
    check("op2_bout", {31'b0, Bout}, 32'd1);
    tick();
    check("op2_ov_clr", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 0x10000000 - 0x0FFFFFFF - 1, then backpressure while new operands are offered
    run_op("op3", 32'h1000_0000, 32'h0FFF_FFFF, 1'b1);
    check("op3_d", D, 32'h0000_0000);
    check("op3_bout", {31'b0, Bout}, 32'd0);
    A = 32'h0000_0020; B = 32'h0000_0008; Bin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_ov", {31'b0, out_valid}, 32'd1);
      check("bp_d", D, 32'h0000_0000);
      check("bp_bout", {31'b0, Bout}, 32'd0);
      check("bp_rdy", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ov_clr", {31'b0, out_valid}, 32'd0);
    check("bp_rdy_idle", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    wait_result("op4");
    check("op4_d", D, 32'h0000_0018);
    check("op4_bout", {31'b0, Bout}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the 4th RUN cycle discards the operation at once
    A = 32'hFFFF_FFFF; B = 32'h0000_0001; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ov", {31'b0, out_valid}, 32'd0);
    check("mid_rst_d", D, 32'd0);
    check("mid_rst_bout", {31'b0, Bout}, 32'd0);
    check("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b1;
    run_op("op5", 32'h0000_000A, 32'h0000_0004, 1'b0);
    check("op5_d", D, 32'h0000_0006);
    check("op5_bout", {31'b0, Bout}, 32'd0);
    tick();

    run_op("op6", 32'h1234_5678, 32'h0234_5679, 1'b0);
    check("op6_d", D, 32'h0FFF_FFFF);
    check("op6_bout", {31'b0, Bout}, 32'd0);
    tick();

    run_op("op7", 32'h0000_0000, 32'h0000_0000, 1'b1);
    check("op7_d", D, 32'hFFFF_FFFF);
    check("op7_bout", {31'b0, Bout}, 32'd1);
    tick();

`ifdef NIBBLE_SUB_OVERFLOW_FLAG_EN
    run_op("ovf1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("ovf1_d", D, 32'h8000_0000);
    check("ovf1_bout", {31'b0, Bout}, 32'd1);
    check("ovf1_ovf", {31'b0, ovf}, 32'd1);
    tick();
    run_op("ovf2", 32'h0000_0005, 32'h0000_0003, 1'b0);
    check("ovf2_d", D, 32'h0000_0002);
    check("ovf2_ovf", {31'b0, ovf}, 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor: D = A - B - Bin over WIDTH bits, one 4-bit nibble per clock, LSB nibble first.
- Borrow ripples between nibbles through an internal borrow register.
- Counterpart to the team's nibble-sliced carry-increment adders; reuses the same 4-bit slicing, but runs in the subtract direction with a valid/ready handshake on both ends.
- Serves area-constrained datapaths where a full-width subtract path is not affordable.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and >= 8; N = WIDTH/4 nibbles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference (registered).
- Bout  output  1  final borrow-out (registered).

Behaviour:
- States:
  - IDLE -> RUN on accept.
  - RUN -> DONE after nibble N-1.
  - DONE -> IDLE when out_ready=1.
- Reset (async, any state, including mid-RUN): state=IDLE, nibble index=0, borrow reg=0, D=0, Bout=0, out_valid=0. An in-flight operation is discarded with no output.
- in_ready = (state==IDLE) and rst low. It is 0 in RUN and DONE.
- Accept: in_valid && in_ready at an edge.
  - Capture A, B, Bin into operand registers; borrow reg=Bin; index=0; go RUN.
  - Inputs are not sampled again until the next accept.
- RUN, each edge:
  - {borrow', d4} = A[4i+3:4i] - B[4i+3:4i] - borrow, evaluated as a 5-bit subtract with borrow = bit 4.
  - Write d4 to D[4i+3:4i]; borrow reg=borrow'; i=i+1.
  - At i==N-1, also load Bout=borrow' and go DONE.
- Latency: accept at edge t; out_valid=1 after edge t+N (N=8 for WIDTH=32).
- DONE:
  - out_valid=1; D and Bout held stable.
  - On out_ready=1 at an edge: out_valid=0 and go IDLE.
  - DONE always lasts >= 1 cycle, even if out_ready was already high.
  - out_valid never drops without out_ready.
- Throughput: at most one operation per N+2 cycles. No overlap; in_valid during RUN/DONE is ignored (no capture).
- D bits of not-yet-processed nibbles during RUN are don't-care. D is only meaningful while out_valid=1.
- Arithmetic is modulo 2^WIDTH. Bout=1 exactly when A < B + Bin (unsigned).

Optional Feature:
- Macro: NIBBLE_SUB_OVERFLOW_FLAG_EN.
- Defined:
  - Extra output port ovf (1 bit, registered, reset 0), loaded alongside Bout.
  - ovf = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), i.e. two's-complement signed overflow, using captured operands.
  - Valid under the same out_valid rules as D.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
- 0x00000005 - 0x00000003, Bin=0 -> D=0x00000002, Bout=0, out_valid rises exactly 8 edges after accept, in_ready=0 throughout RUN/DONE.
- 0x00000000 - 0x00000001, Bin=0 -> D=0xFFFFFFFF, Bout=1 (borrow ripples through all 8 nibbles).
- 0x10000000 - 0x0FFFFFFF, Bin=1 -> D=0x00000000, Bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> D/Bout/out_valid stable, no capture. Raise out_ready -> out_valid=0 next edge, in_ready=1, and the new operands are accepted on the following edge.
- Assert rst at the 4th RUN cycle -> out_valid, D, Bout read 0 immediately, with no clock edge needed. After release: in_ready=1, and a fresh 0x0000000A - 0x00000004 yields D=0x00000006.
- With NIBBLE_SUB_OVERFLOW_FLAG_EN: 0x7FFFFFFF - 0xFFFFFFFF -> D=0x80000000, Bout=1, ovf=1. Then 0x00000005 - 0x00000003 -> ovf=0.
